set_assoc_dcache: RTL and testbench
===================================

# set_assoc_dcache

Parametrised N-way set-associative, multi-word-line, write-through / no-write-allocate data cache between the CPU load/store stage and main memory. It generalises the single-word 2-way cache to configurable sets, ways and line length, with tree pseudo-LRU replacement. A stall handshake holds the CPU during line refills and during write-through transfers to a memory port that has variable latency.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; multiple of 8
- NUM_SETS, 256, power of two, ≥2
- NUM_WAYS, 2, power of two, 1–8
- WORDS_PER_LINE, 4, power of two, ≥1

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  CPU access valid; held with addr/data stable while stall_o=1
- write_en_i  in  1  1=store, 0=load
- addr_i  in  ADDR_WIDTH  byte address
- write_data_i  in  DATA_WIDTH  store data
- byte_en_i  in  DATA_WIDTH/8  store byte lanes
- read_data_o  out  DATA_WIDTH  load data, valid when req_i & !write_en_i & !stall_o
- stall_o  out  1  CPU must hold request
- hit_o  out  1  lookup hit (combinational)
- mem_req_o  out  1  memory transaction request
- mem_write_en_o  out  1  transaction is write
- mem_addr_o  out  ADDR_WIDTH  word-aligned address
- mem_write_data_o  out  DATA_WIDTH  write data
- mem_byte_en_o  out  DATA_WIDTH/8  write lanes
- mem_ready_i  in  1  transaction accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_read_data_i  in  DATA_WIDTH  read data

## Operation
- Address split: byte offset [log2(DATA_WIDTH/8)-1:0], word index, set index, tag = remaining upper bits.
- Per way/set: valid, tag, WORDS_PER_LINE data words. Per set: NUM_WAYS-1 PLRU bits; NUM_WAYS=1 has none.
- FSM states: IDLE, WRITE, RF_REQ, RF_WAIT.
- IDLE, load hit: read_data_o = hit word in the same cycle, stall_o=0, PLRU updated toward the hit way.
- IDLE, load miss: stall_o=1. The victim is the lowest-index invalid way, else the PLRU victim, and is latched. The victim's valid bit is cleared, its tag is written, the word counter is set to 0, and the FSM goes to RF_REQ.
- RF_REQ: mem_req_o=1, mem_write_en_o=0, mem_addr_o={tag,set,counter,0}. On mem_ready_i, go to RF_WAIT.
- RF_WAIT: on mem_rvalid_i, write the word to the victim. If it is the last word, set valid, mark the victim most-recent, and go to IDLE. Otherwise increment the counter and go to RF_REQ.
- Only one memory transaction is outstanding at a time. Words are filled in order 0..WORDS_PER_LINE-1.
- After a refill, the held load is re-looked-up in IDLE and hits.
- IDLE, store: stall_o=1, go to WRITE. Hit/miss result is not used for memory traffic.
- WRITE: mem_req_o=1, mem_write_en_o=1, mem_addr_o = word-aligned address, data/byte_en passed through. stall_o = !mem_ready_i.
- On acceptance of a store: if it hits, update the hit way's word under byte_en_i and update PLRU; then go to IDLE. A store miss allocates nothing.
- read_data_o = 0 when there is no hit. hit_o = 0 when req_i=0.
- mem_rvalid_i outside RF_WAIT is ignored.

## Timing
- Reset (asynchronous): all valid and PLRU bits cleared, FSM to IDLE. While rst_i=1: stall_o=0, hit_o=0, read_data_o=0, mem_req_o=0, mem_write_en_o=0, mem_addr_o=0, mem_write_data_o=0, mem_byte_en_o=0.
- Data and tag arrays are not reset.
- Load hit: 0 added cycles.
- Load miss: 1 + Σ(accept wait + read latency) per word, then 1 hit cycle.
- Store: minimum 2 cycles (IDLE, WRITE with mem_ready_i=1).
- Reset mid-refill: the partial line stays invalid, mem_req_o drops asynchronously, and late mem_rvalid_i is ignored.
- Simultaneous hit in two ways cannot occur; no handling is required.

## Configuration
- DCACHE_PERF_CNT_EN defined: adds outputs read_hit_cnt_o and read_miss_cnt_o, both 32-bit, reset 0, wrapping.
  - read_hit_cnt_o increments on each completed load hit (stall_o=0).
  - read_miss_cnt_o increments on each refill start.
- DCACHE_PERF_CNT_EN undefined: neither port nor counter logic exists.

## Test plan
All scenarios use the default parameters: tag [31:12], set [11:4], word [3:2].
- Reset, then load 0x1000 with memory words 0x11223344, 0xA1, 0xA2, 0xA3 and 1-cycle rvalid -> four reads at 0x1000/04/08/0C. stall_o stays high throughout. The next cycle returns 0x11223344 with a hit. Load 0x1008 returns 0xA2 with mem_req_o=0.
- Store 0xDEADBEEF to 0x1000 with byte_en 0011, mem_ready_i delayed 3 cycles -> stall_o high until accept. mem_byte_en_o=0011. A following load of 0x1000 returns 0x1122BEEF.
- Store to 0x5000 (miss) -> one memory write, no refill. A following load of 0x5000 misses and refills.
- PLRU, 2 ways: load 0x1000, then 0x2000, then 0x1000 (hit), then 0x3000 -> 0x2000 is evicted. 0x1000 still hits; 0x2000 misses.
- Assert rst_i after the second refill word of 0x7000 -> mem_req_o=0 immediately. A stray mem_rvalid_i is ignored. Reload of 0x7000 refills from 0x7000.
- With DCACHE_PERF_CNT_EN: the first scenario gives read_miss_cnt_o=1 and read_hit_cnt_o=2.

Source files
------------

// File: rtl/set_assoc_dcache.sv
// set_assoc_dcache: N-way set-associative, multi-word-line, write-through / no-write-allocate data cache with tree PLRU.
// Defining DCACHE_PERF_CNT_EN adds the read_hit_cnt_o / read_miss_cnt_o counters.
module set_assoc_dcache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 256,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    write_en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    stall_o,
  output logic                    hit_o,
  output logic                    mem_req_o,
  output logic                    mem_write_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_write_data_o,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_read_data_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]             read_hit_cnt_o,
  output logic [31:0]             read_miss_cnt_o
`endif
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int OFF_BITS  = $clog2(BE_W);
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int SET_BITS  = $clog2(NUM_SETS);
  localparam int WAY_LVLS  = $clog2(NUM_WAYS);
  localparam int TAG_LSB   = OFF_BITS + WORD_BITS + SET_BITS;
  localparam int TAG_BITS  = ADDR_WIDTH - TAG_LSB;
  localparam int CNT_W     = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int WAY_W     = (WAY_LVLS > 0) ? WAY_LVLS : 1;
  localparam int PLRU_W    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BE_W - 1);
  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, RF_REQ, RF_WAIT} state_e;

  state_e                            state_q, state_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] validBits_q;
  logic [NUM_SETS-1:0][PLRU_W-1:0]   plruBits_q;
  logic [TAG_BITS-1:0]               tagArray_q  [NUM_WAYS][NUM_SETS];
  logic [DATA_WIDTH-1:0]             dataArray_q [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [WAY_W-1:0]                  victim_q;
  logic [CNT_W-1:0]                  wordCnt_q;

  logic [TAG_BITS-1:0]   reqTag;
  logic [SET_BITS-1:0]   reqSet;
  logic [CNT_W-1:0]      reqWord;
  logic                  hitAny, invalidFound;
  logic [WAY_W-1:0]      hitWay, victimSel;
  logic [DATA_WIDTH-1:0] hitWord, mergedWord;
  logic [ADDR_WIDTH-1:0] fillAddr;
  logic                  stallRaw, fillStart, fillWord, fillLast, loadHit, storeHit;

  // Tree walk: each node bit points toward the less recently used half.
  function automatic logic [PLRU_W-1:0] plruTouch(input logic [PLRU_W-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [PLRU_W-1:0] res;
    logic              dir;
    int                node;
    res  = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_LVLS; lvl++) begin
      dir       = way[WAY_LVLS-1-lvl];
      res[node] = ~dir;
      node      = 2 * node + 1 + int'(dir);
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plruVictim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    logic             dir;
    int               node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_LVLS; lvl++) begin
      dir  = bits[node];
      way  = (way << 1) | WAY_W'(dir);
      node = 2 * node + 1 + int'(dir);
    end
    return way;
  endfunction

  assign reqTag   = TAG_BITS'(addr_i >> TAG_LSB);
  assign reqSet   = SET_BITS'(addr_i >> (OFF_BITS + WORD_BITS));
  assign reqWord  = (WORD_BITS > 0) ? CNT_W'(addr_i >> OFF_BITS) : '0;
  assign fillAddr = (ADDR_WIDTH'(reqTag) << TAG_LSB)
                  | (ADDR_WIDTH'(reqSet) << (OFF_BITS + WORD_BITS))
                  | (ADDR_WIDTH'(wordCnt_q) << OFF_BITS);

  always_comb begin
    hitAny       = 1'b0;
    hitWay       = '0;
    invalidFound = 1'b0;
    victimSel    = plruVictim(plruBits_q[reqSet]);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (validBits_q[reqSet][w] && (tagArray_q[w][reqSet] == reqTag)) begin
        hitAny = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!validBits_q[reqSet][w]) begin
        invalidFound = 1'b1;
        victimSel    = WAY_W'(w);
      end
    end
    hitWord    = dataArray_q[hitWay][reqSet][reqWord];
    mergedWord = hitWord;
    for (int b = 0; b < BE_W; b++) begin
      if (byte_en_i[b]) mergedWord[8*b +: 8] = write_data_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d          = state_q;
    stallRaw         = 1'b0;
    mem_req_o        = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_byte_en_o    = '0;
    fillStart        = 1'b0;
    fillWord         = 1'b0;
    fillLast         = 1'b0;
    loadHit          = 1'b0;
    storeHit         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (write_en_i) begin
            stallRaw = 1'b1;
            state_d  = WRITE;
          end else if (hitAny) begin
            loadHit = 1'b1;
          end else begin
            stallRaw  = 1'b1;
            fillStart = 1'b1;
            state_d   = RF_REQ;
          end
        end
      end
      WRITE: begin
        mem_req_o        = 1'b1;
        mem_write_en_o   = 1'b1;
        mem_addr_o       = addr_i & ~OFF_MASK;
        mem_write_data_o = write_data_i;
        mem_byte_en_o    = byte_en_i;
        stallRaw         = ~mem_ready_i;
        if (mem_ready_i) begin
          storeHit = hitAny;
          state_d  = IDLE;
        end
      end
      RF_REQ: begin
        stallRaw   = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = fillAddr;
        if (mem_ready_i) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        stallRaw = 1'b1;
        if (mem_rvalid_i) begin
          fillWord = 1'b1;
          if (wordCnt_q == LAST_WORD) begin
            fillLast = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = RF_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The CPU-facing outputs must read as idle while reset is held, even with a request present.
  assign stall_o     = stallRaw & ~rst_i;
  assign hit_o       = req_i & hitAny & ~rst_i;
  assign read_data_o = hit_o ? hitWord : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      validBits_q <= '0;
      plruBits_q  <= '0;
      victim_q    <= '0;
      wordCnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fillStart) begin
        victim_q                          <= victimSel;
        wordCnt_q                         <= '0;
        validBits_q[reqSet][victimSel]    <= 1'b0;
      end
      if (fillWord && !fillLast) wordCnt_q <= wordCnt_q + 1'b1;
      if (fillLast) begin
        validBits_q[reqSet][victim_q] <= 1'b1;
        plruBits_q[reqSet]            <= plruTouch(plruBits_q[reqSet], victim_q);
      end else if (loadHit || storeHit) begin
        plruBits_q[reqSet]            <= plruTouch(plruBits_q[reqSet], hitWay);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fillStart) tagArray_q[victimSel][reqSet] <= reqTag;
    if (fillWord)  dataArray_q[victim_q][reqSet][wordCnt_q] <= mem_read_data_i;
    if (storeHit)  dataArray_q[hitWay][reqSet][reqWord] <= mergedWord;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] readHitCnt_q, readMissCnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      readHitCnt_q  <= '0;
      readMissCnt_q <= '0;
    end else begin
      if (loadHit)   readHitCnt_q  <= readHitCnt_q + 32'd1;
      if (fillStart) readMissCnt_q <= readMissCnt_q + 32'd1;
    end
  end

  assign read_hit_cnt_o  = readHitCnt_q;
  assign read_miss_cnt_o = readMissCnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_dcache.sv
// tb_set_assoc_dcache: table-driven bench for set_assoc_dcache with a reactive memory model
// and a transaction scoreboard comparing expected against issued memory traffic.
module tb_set_assoc_dcache;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req_i = 1'b0;
   logic        write_en_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] write_data_i = '0;
   logic [3:0]  byte_en_i = '0;
   logic [31:0] read_data_o;
   logic        stall_o, hit_o;
   logic        mem_req_o, mem_write_en_o;
   logic [31:0] mem_addr_o, mem_write_data_o;
   logic [3:0]  mem_byte_en_o;
   logic        mem_ready_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_read_data_i = '0;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] read_hit_cnt_o, read_miss_cnt_o;
`endif

   set_assoc_dcache dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .req_i            (req_i),
      .write_en_i       (write_en_i),
      .addr_i           (addr_i),
      .write_data_i     (write_data_i),
      .byte_en_i        (byte_en_i),
      .read_data_o      (read_data_o),
      .stall_o          (stall_o),
      .hit_o            (hit_o),
      .mem_req_o        (mem_req_o),
      .mem_write_en_o   (mem_write_en_o),
      .mem_addr_o       (mem_addr_o),
      .mem_write_data_o (mem_write_data_o),
      .mem_byte_en_o    (mem_byte_en_o),
      .mem_ready_i      (mem_ready_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_read_data_i  (mem_read_data_i)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .read_hit_cnt_o   (read_hit_cnt_o),
      .read_miss_cnt_o  (read_miss_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } txn_t;

   typedef struct {
      logic        rstBefore;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          readyDly;
      logic        expMiss;
      logic [31:0] expData;
      logic        expHit;
      int          expStall;
   } vec_t;

   txn_t expTxn[$];
   txn_t actTxn[$];
   logic [31:0] memArr [logic [31:0]];

   int checkCount = 0;
   int passCount = 0;

   int readyDly = 0;
   int acceptLimit = -1;
   int strayReq = 0;
   int acceptTotal = 0;
   int rvalidSent = 0;
   int strayDone = 0;
   int waitCnt = 0;
   logic        rvalidPending = 1'b0;
   logic [31:0] pendingData = '0;

   // Background words for addresses the test never preloads or stores to.
   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memArr.exists(a)) return memArr[a];
      case (a)
         32'h1000: return 32'h1122_3344;
         32'h1004: return 32'h0000_00A1;
         32'h1008: return 32'h0000_00A2;
         32'h100C: return 32'h0000_00A3;
         default:  return dflt(a);
      endcase
   endfunction

   // Memory responder: acts 2ns after each falling edge so it sees the CPU inputs already driven.
   always @(negedge clk_i) begin
      logic [31:0] merged;
      #2;
      mem_ready_i     = 1'b0;
      mem_rvalid_i    = 1'b0;
      mem_read_data_i = '0;
      if (strayDone != strayReq) begin
         mem_rvalid_i    = 1'b1;
         mem_read_data_i = 32'hBADB_AD00;
         strayDone++;
      end else if (rvalidPending) begin
         mem_rvalid_i    = 1'b1;
         mem_read_data_i = pendingData;
         rvalidPending   = 1'b0;
         rvalidSent++;
      end else if (mem_req_o && (acceptLimit < 0 || acceptTotal < acceptLimit)) begin
         if (waitCnt < readyDly) begin
            waitCnt++;
         end else begin
            mem_ready_i = 1'b1;
            waitCnt = 0;
            acceptTotal++;
            actTxn.push_back('{mem_write_en_o, mem_addr_o, mem_write_data_o, mem_byte_en_o});
            if (mem_write_en_o) begin
               merged = memRead(mem_addr_o);
               for (int b = 0; b < 4; b++)
                  if (mem_byte_en_o[b]) merged[8*b +: 8] = mem_write_data_o[8*b +: 8];
               memArr[mem_addr_o] = merged;
            end else begin
               rvalidPending = 1'b1;
               pendingData   = memRead(mem_addr_o);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      req_i        = req;
      write_en_i   = we;
      addr_i       = addr;
      write_data_i = wdata;
      byte_en_i    = be;
   endtask

   task automatic doReset();
      @(negedge clk_i);
      rst_i = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic pushLineRefill(input logic [31:0] addr);
      for (int k = 0; k < 4; k++)
         expTxn.push_back('{1'b0, (addr & ~32'hF) + 32'(4 * k), 32'h0, 4'h0});
   endtask

   // One CPU access held until stall_o drops; results are sampled 3ns after the falling edge.
   task automatic runAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output int stallCycles, output logic [31:0] rdata,
                            output logic hitSeen, output logic memReqSeen);
      @(negedge clk_i);
      applyStimulus(1'b1, we, addr, wdata, be);
      #3;
      stallCycles = 0;
      while (stall_o && stallCycles < 200) begin
         stallCycles++;
         @(negedge clk_i);
         #3;
      end
      if (stall_o) checkOutput("stall release", 32'(stall_o), 32'h0);
      rdata      = read_data_o;
      hitSeen    = hit_o;
      memReqSeen = mem_req_o;
      @(negedge clk_i);
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drainScoreboard(input string tag);
      txn_t a, e;
      checkOutput({tag, " txn count"}, 32'(actTxn.size()), 32'(expTxn.size()));
      while (actTxn.size() > 0 && expTxn.size() > 0) begin
         a = actTxn.pop_front();
         e = expTxn.pop_front();
         checkOutput({tag, " txn we"}, 32'(a.we), 32'(e.we));
         checkOutput({tag, " txn addr"}, a.addr, e.addr);
         if (e.we) begin
            checkOutput({tag, " txn wdata"}, a.data, e.data);
            checkOutput({tag, " txn byte_en"}, 32'(a.be), 32'(e.be));
         end
      end
      actTxn.delete();
      expTxn.delete();
   endtask

   initial begin
      vec_t        vecs[12];
      int          stallCycles, baseRv, waitCycles;
      logic [31:0] rdata;
      logic        hitSeen, memReqSeen;
      string       tag;

      vecs[0]  = '{1'b0, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 1'b1, 32'h1122_3344, 1'b1, 9};
      vecs[1]  = '{1'b0, 1'b0, 32'h1008, 32'h0,         4'h0, 0, 1'b0, 32'h0000_00A2, 1'b1, 0};
      vecs[2]  = '{1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'h3, 3, 1'b0, 32'h0,         1'b1, 4};
      vecs[3]  = '{1'b0, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 1'b0, 32'h1122_BEEF, 1'b1, 0};
      vecs[4]  = '{1'b0, 1'b1, 32'h5000, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1};
      vecs[5]  = '{1'b0, 1'b0, 32'h5000, 32'h0,         4'h0, 0, 1'b1, 32'hCAFE_F00D, 1'b1, 9};
      vecs[6]  = '{1'b1, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 1'b1, 32'h1122_BEEF, 1'b1, 9};
      vecs[7]  = '{1'b0, 1'b0, 32'h2000, 32'h0,         4'h0, 0, 1'b1, dflt(32'h2000), 1'b1, 9};
      vecs[8]  = '{1'b0, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 1'b0, 32'h1122_BEEF, 1'b1, 0};
      vecs[9]  = '{1'b0, 1'b0, 32'h3000, 32'h0,         4'h0, 0, 1'b1, dflt(32'h3000), 1'b1, 9};
      vecs[10] = '{1'b0, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 1'b0, 32'h1122_BEEF, 1'b1, 0};
      vecs[11] = '{1'b0, 1'b0, 32'h2000, 32'h0,         4'h0, 0, 1'b1, dflt(32'h2000), 1'b1, 9};

      // Outputs must stay idle while reset is held, even with a load pending.
      #2 rst_i = 1'b1;
      #1 applyStimulus(1'b1, 1'b0, 32'h1000, '0, '0);
      #1;
      checkOutput("reset stall_o", 32'(stall_o), 32'h0);
      checkOutput("reset hit_o", 32'(hit_o), 32'h0);
      checkOutput("reset read_data_o", read_data_o, 32'h0);
      checkOutput("reset mem_req_o", 32'(mem_req_o), 32'h0);
      checkOutput("reset mem_addr_o", mem_addr_o, 32'h0);
      repeat (2) @(negedge clk_i);
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      rst_i = 1'b0;

      for (int i = 0; i < 12; i++) begin
         tag = $sformatf("vec%0d", i);
         if (vecs[i].rstBefore) doReset();
         readyDly = vecs[i].readyDly;
         if (vecs[i].we)
            expTxn.push_back('{1'b1, vecs[i].addr & ~32'h3, vecs[i].wdata, vecs[i].be});
         else if (vecs[i].expMiss)
            pushLineRefill(vecs[i].addr);
         runAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   stallCycles, rdata, hitSeen, memReqSeen);
         checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(vecs[i].expStall));
         checkOutput({tag, " hit_o"}, 32'(hitSeen), 32'(vecs[i].expHit));
         checkOutput({tag, " mem_req_o"}, 32'(memReqSeen), 32'(vecs[i].we));
         if (!vecs[i].we) checkOutput({tag, " read_data_o"}, rdata, vecs[i].expData);
         drainScoreboard(tag);
`ifdef DCACHE_PERF_CNT_EN
         if (i == 1) begin
            checkOutput("perf read_miss_cnt_o", read_miss_cnt_o, 32'd1);
            checkOutput("perf read_hit_cnt_o", read_hit_cnt_o, 32'd2);
         end
`endif
      end

      // Reset in the middle of a refill: only two words are ever accepted before reset.
      doReset();
      readyDly    = 0;
      acceptLimit = acceptTotal + 2;
      expTxn.push_back('{1'b0, 32'h7000, 32'h0, 4'h0});
      expTxn.push_back('{1'b0, 32'h7004, 32'h0, 4'h0});
      baseRv = rvalidSent;
      @(negedge clk_i);
      applyStimulus(1'b1, 1'b0, 32'h7000, '0, '0);
      waitCycles = 0;
      while (rvalidSent < baseRv + 2 && waitCycles < 100) begin
         @(negedge clk_i);
         #3;
         waitCycles++;
      end
      checkOutput("midfill rvalid count", 32'(rvalidSent), 32'(baseRv + 2));
      @(posedge clk_i);
      #1;
      checkOutput("midfill mem_req_o before reset", 32'(mem_req_o), 32'h1);
      rst_i = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      #1;
      checkOutput("midfill mem_req_o async drop", 32'(mem_req_o), 32'h0);
      checkOutput("midfill stall_o in reset", 32'(stall_o), 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      strayReq++;
      repeat (2) @(negedge clk_i);
      acceptLimit = -1;
      drainScoreboard("midfill");

      pushLineRefill(32'h7000);
      runAccess(1'b0, 32'h7000, '0, '0, stallCycles, rdata, hitSeen, memReqSeen);
      checkOutput("reload 0x7000 stall cycles", 32'(stallCycles), 32'd9);
      checkOutput("reload 0x7000 read_data_o", rdata, dflt(32'h7000));
      checkOutput("reload 0x7000 hit_o", 32'(hitSeen), 32'h1);
      drainScoreboard("reload");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
